// File: rtl/vt_encode_seq.sv
// vt_encode_seq: sequential Varshamov-Tenengolts style encoder.
// Places K information bits on the non-parity positions of an N-bit codeword,
// then fills parity positions (powers of two, plus position N when spare) so
// that the weighted position sum mod M = 2N+1 equals the requested syndrome A.
// Positions are walked serially: ascending 1..N for the data, then descending
// N..1 for the parity.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           input handshake (ready only in IDLE)
//   data_in[K], syn_in[SW]        information bits and target syndrome A
//   out_valid / out_ready         result handshake (valid only in DONE)
//   codeword[N]                   bit i is position i+1
//   good_syndrome                 weighted sum mod M equals A
//   busy                          high whenever the FSM is not in IDLE

package vt_encode_seq_pkg;
  // Smallest codeword length n with k <= n - clog2(n) - 1.
  function automatic int unsigned calc_n(input int unsigned k);
    int unsigned n;
    n = 0;
    for (int unsigned c = 2; c < 256; c++) begin
      if (n == 0 && (k + $clog2(c) + 1) <= c) n = c;
    end
    return n;
  endfunction
endpackage

module vt_encode_seq #(
  parameter int unsigned K = 5,
  parameter int unsigned N = vt_encode_seq_pkg::calc_n(K)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [K-1:0]                 data_in,
  input  logic [$clog2(2*N+1)-1:0]     syn_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 codeword,
  output logic                         good_syndrome,
  output logic                         busy
);

  localparam int unsigned M     = 2 * N + 1;
  localparam int unsigned SW    = $clog2(M);
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned DW    = $clog2(K + 1);
  localparam int unsigned SUMW  = $clog2(N * (N + 1) / 2 + 1);
  localparam int unsigned LOG_L = $clog2(N + 1) - 1;
  // Position N is an extra parity slot when the power-of-two slots leave room.
  localparam bit          EXTRA_PAR = ((K + LOG_L + 1) < N);

  typedef enum logic [1:0] {IDLE, ACCUM, PARITY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   didx;
  logic [K-1:0]    data_r;
  logic [SW-1:0]   a_r;
  logic [SUMW-1:0] s_r;
  logic [SW-1:0]   p_r;

  logic            pos_par;
  logic            dbit;
  logic            take;
  logic            good_calc;
  logic [K-1:0]    data_sh;
  logic [N-1:0]    pos_mask;
  logic [SUMW-1:0] s_acc;
  logic [SUMW-1:0] s_par;
  logic [SW-1:0]   p_calc;

  function automatic logic is_par(input logic [CW-1:0] p);
    return ((p & (p - CW'(1))) == '0) || (EXTRA_PAR && (p == CW'(N)));
  endfunction

  // Per-position datapath for the current counter value.
  always_comb begin
    pos_par   = is_par(cnt);
    data_sh   = data_r >> didx;
    dbit      = data_sh[0];
    pos_mask  = N'(1) << (cnt - CW'(1));
    s_acc     = s_r + ((dbit && !pos_par) ? SUMW'(cnt) : SUMW'(0));
    // Parity budget P = (A - S) mod M, kept non-negative.
    p_calc    = SW'(((32'(a_r) % M) + M - (32'(s_acc) % M)) % M);
    take      = pos_par && (32'(p_r) >= 32'(cnt));
    s_par     = s_r + (take ? SUMW'(cnt) : SUMW'(0));
    good_calc = (32'(a_r) < M) && ((32'(s_par) % M) == 32'(a_r));
  end

  // Control FSM and registered outputs. out_valid rises 2N edges after the
  // accepting edge, i.e. in the (2N+1)-th cycle counting the accepting one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      didx          <= '0;
      data_r        <= '0;
      a_r           <= '0;
      s_r           <= '0;
      p_r           <= '0;
      codeword      <= '0;
      good_syndrome <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r   <= data_in;
            a_r      <= syn_in;
            codeword <= '0;
            s_r      <= '0;
            p_r      <= '0;
            cnt      <= CW'(1);
            didx     <= '0;
            state    <= ACCUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (!pos_par) begin
            codeword <= dbit ? (codeword | pos_mask) : (codeword & ~pos_mask);
            didx     <= didx + DW'(1);
          end
          s_r <= s_acc;
          if (cnt == CW'(N)) begin
            p_r   <= p_calc;
            state <= PARITY;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (pos_par) begin
            codeword <= take ? (codeword | pos_mask) : (codeword & ~pos_mask);
            if (take) p_r <= p_r - SW'(cnt);
          end
          s_r <= s_par;
          if (cnt == CW'(1)) begin
            good_syndrome <= good_calc;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vt_encode_seq.sv
// Testbench for vt_encode_seq (K=5, N=10, M=21): directed cases plus
// randomized words checked against a behavioural encoder model.
module tb_vt_encode_seq;

  localparam int K  = 5;
  localparam int N  = 10;
  localparam int M  = 21;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  data_in;
  logic [SW-1:0] syn_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  codeword;
  logic          good_syndrome;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vt_encode_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_in       (data_in),
    .syn_in        (syn_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .codeword      (codeword),
    .good_syndrome (good_syndrome),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_par(input int p);
    int l;
    l = 1;
    while (l * 2 <= N) l = l * 2;
    return ((p & (p - 1)) == 0) || (p == N && (K + $clog2(l) + 1) < N);
  endfunction

  // Behavioural encoder: data on non-parity slots, then greedy parity fill.
  function automatic void model(input int d, input int a, output int cw, output int good);
    int s, j, prem;
    cw = 0; s = 0; j = 0;
    for (int p = 1; p <= N; p++) begin
      if (!is_par(p)) begin
        if (((d >> j) & 1) == 1) begin
          cw = cw | (1 << (p - 1));
          s  = s + p;
        end
        j++;
      end
    end
    prem = ((a - s) % M + M) % M;
    for (int p = N; p >= 1; p--) begin
      if (is_par(p) && prem >= p) begin
        cw   = cw | (1 << (p - 1));
        prem = prem - p;
        s    = s + p;
      end
    end
    good = (a < M && (s % M) == a) ? 1 : 0;
  endfunction

  function automatic int wsum(input int cw);
    int s;
    s = 0;
    for (int p = 1; p <= N; p++) if (((cw >> (p - 1)) & 1) == 1) s = s + p;
    return s;
  endfunction

  // One word end to end; optional inputs noise while busy and DONE hold time.
  task automatic send(input int d, input int a, input int hold, input bit noisy,
                      output int cw_o, output int good_o);
    int edges, exp_cw, exp_good;
    logic [N-1:0] cw_hold;
    model(d, a, exp_cw, exp_good);
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    data_in   = K'(d);
    syn_in    = SW'(a);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = noisy;
    data_in  = K'($urandom);
    syn_in   = SW'($urandom);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (noisy) begin
        data_in = K'($urandom);
        syn_in  = SW'($urandom);
      end
    end
    chk("latency_edges", 32'(edges), 32'(2 * N));
    chk("codeword", 32'(codeword), 32'(exp_cw));
    chk("good_syndrome", 32'(good_syndrome), 32'(exp_good));
    cw_o    = int'(codeword);
    good_o  = int'(good_syndrome);
    cw_hold = codeword;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_in  = K'($urandom);
      syn_in   = SW'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_codeword", 32'(codeword), 32'(cw_hold));
      chk("hold_status", 32'({out_valid, in_ready}), 32'(2'b10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", 32'({out_valid, busy, in_ready}), 32'(3'b001));
    chk("idle_keeps_cw", 32'(codeword), 32'(cw_hold));
  endtask

  initial begin
    int cw, good, d, a, seen, dgot;
    int dpos[5] = '{3, 5, 6, 7, 9};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; syn_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({codeword, good_syndrome, out_valid, busy}), 32'd0);
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed words; the first is offered right as reset releases.
    send(5'b11111, 0, 0, 1'b0, cw, good);
    chk("dir_1f_cw", 32'(cw), 32'h376);
    chk("dir_1f_good", 32'(good), 32'd1);
    send(5'b00001, 0, 0, 1'b0, cw, good);
    chk("dir_01_cw", 32'(cw), 32'h284);
    chk("dir_01_good", 32'(good), 32'd1);
    send(0, 5, 0, 1'b0, cw, good);
    chk("dir_00a5_cw", 32'(cw), 32'h009);
    chk("dir_00a5_good", 32'(good), 32'd1);
    send(0, 21, 0, 1'b0, cw, good);
    chk("dir_a21_good", 32'(good), 32'd0);
    // Long DONE hold with a competing in_valid and input noise.
    send(5'b10101, 13, 10, 1'b1, cw, good);

    // Reset while in PARITY discards the word at once.
    in_valid = 1'b1; data_in = 5'b10110; syn_in = 5'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) begin @(posedge clk); @(negedge clk); end
    chk("busy_in_parity", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_clear", 32'({codeword, good_syndrome, out_valid, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("no_out_after_rst", 32'(seen), 32'd0);
    send(5'b10110, 7, 2, 1'b0, cw, good);

    // Randomized words with random DONE hold and input noise.
    for (int i = 0; i < 1000; i++) begin
      d = int'($urandom_range(0, 31));
      a = int'($urandom_range(0, M - 1));
      send(d, a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), cw, good);
      dgot = 0;
      for (int j = 0; j < 5; j++) dgot = dgot | (((cw >> (dpos[j] - 1)) & 1) << j);
      chk("rand_data_bits", 32'(dgot), 32'(d));
      chk("rand_syndrome", 32'(wsum(cw) % M), 32'(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
